// File: rtl/mem_pkg.sv
// mem_pkg: widths, descriptor type and streamer states shared by the memory block and its ports
package mem_pkg;
  localparam int MEM_DATA_W = 128;
  localparam int MEM_ADDR_W = 12;
  localparam int MEM_LEN_W = 13;
  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_LEN_W-1:0] len;
  } ob_cmd_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} ob_state_t;
endpackage

// File: rtl/mem_ob_fifo.sv
// mem_ob_fifo: synchronous fifo with a registered head entry and occupancy count
module mem_ob_fifo #(
  parameter int W = 129,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  head,
  output logic          head_valid,
  output logic [CW-1:0] count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp, rp_n;
  logic [CW-1:0] cnt_n;
  always_comb begin
    rp_n = rp + AW'(rd_en);
    cnt_n = count + CW'(wr_en) - CW'(rd_en);
  end
  always_ff @(posedge clk)
    if (wr_en) mem[wp] <= wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      head <= '0;
      head_valid <= 1'b0;
    end else begin
      wp <= wp + AW'(wr_en);
      rp <= rp_n;
      count <= cnt_n;
      head_valid <= cnt_n != '0;
      if (wr_en || rd_en) head <= (wr_en && rp_n == wp) ? wr_data : mem[rp_n];
    end
endmodule

// File: rtl/mem_ob_streamer.sv
// mem_ob_streamer: descriptor-driven sequential reader turning memory read returns into a valid/ready stream
module mem_ob_streamer
  import mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int LEN_W = MEM_LEN_W,
  parameter int RD_LAT = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              ObRdEn,
  output logic [ADDR_W-1:0] ObRdAddr,
  input  logic [DATA_W-1:0] ObRdData,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(FIFO_DEPTH + RD_LAT + 3);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << (LEN_W - 1);
  ob_state_t state, state_n;
  logic [ADDR_W-1:0] addr, addr_n, iss_addr;
  logic [LEN_W-1:0] rem, rem_n, len_c;
  logic [RD_LAT-1:0] pv, pl;
  logic [CW-1:0] cnt;
  logic [OW-1:0] outstanding;
  logic [DATA_W:0] head;
  logic ob_last, issue, iss_last, accept, pop, done_n;
  assign len_c = cmd_len > MAX_LEN ? MAX_LEN : cmd_len;
  assign accept = cmd_valid && cmd_ready;
  assign pop = m_valid && m_ready;
  assign m_last = head[DATA_W];
  assign m_data = head[DATA_W-1:0];
  always_comb begin
    outstanding = OW'(cnt) + OW'(ObRdEn);
    for (int i = 0; i < RD_LAT; i++) outstanding += OW'(pv[i]);
  end
  always_comb begin
    state_n = state;
    addr_n = addr;
    rem_n = rem;
    iss_addr = addr;
    issue = 1'b0;
    done_n = 1'b0;
    if (state == IDLE && accept) begin
      iss_addr = cmd_addr;
      rem_n = len_c;
      issue = len_c != '0;
      done_n = len_c == '0;
    end else if (state == RUN) begin
      issue = outstanding < OW'(FIFO_DEPTH) + OW'(pop);
    end else if (state == DRAIN && pop && m_last) begin
      state_n = IDLE;
      done_n = 1'b1;
    end
    iss_last = rem_n == LEN_W'(1);
    if (issue) begin
      addr_n = iss_addr + ADDR_W'(1);
      rem_n = rem_n - LEN_W'(1);
      state_n = rem_n == '0 ? DRAIN : RUN;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      ObRdEn <= 1'b0;
      ObRdAddr <= '0;
      ob_last <= 1'b0;
      pv <= '0;
      pl <= '0;
      cmd_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      rem <= rem_n;
      ObRdEn <= issue;
      ob_last <= issue && iss_last;
      if (issue) ObRdAddr <= iss_addr;
      pv <= RD_LAT'({pv, ObRdEn});
      pl <= RD_LAT'({pl, ob_last});
      cmd_ready <= state_n == IDLE;
      busy <= state_n != IDLE;
      done <= done_n;
    end
  mem_ob_fifo #(.W(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(pv[RD_LAT-1]),
    .wr_data({pl[RD_LAT-1], ObRdData}),
    .rd_en(pop),
    .head(head),
    .head_valid(m_valid),
    .count(cnt)
  );
endmodule

// File: tb/tb_mem_ob_streamer.sv
// tb_mem_ob_streamer: randomized streaming against a queue-based reference of descriptor semantics
module tb_mem_ob_streamer;
  localparam int DW = 128, AW = 12, LW = 13, LAT = 1, DEP = 4, LAT2 = 3, DEP2 = 8;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_ready, ObRdEn, m_valid, m_ready = 1, m_last, busy, done;
  logic [AW-1:0] cmd_addr = '0, ObRdAddr;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] ObRdData, m_data;
  logic cmd_valid2 = 0, cmd_ready2, ObRdEn2, m_valid2, m_last2, busy2, done2;
  logic [AW-1:0] cmd_addr2 = '0, ObRdAddr2;
  logic [LW-1:0] cmd_len2 = '0;
  logic [DW-1:0] ObRdData2, m_data2;
  mem_ob_streamer #(.RD_LAT(LAT), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .ObRdEn(ObRdEn), .ObRdAddr(ObRdAddr), .ObRdData(ObRdData),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy), .done(done)
  );
  mem_ob_streamer #(.RD_LAT(LAT2), .FIFO_DEPTH(DEP2)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_addr(cmd_addr2),
    .cmd_len(cmd_len2), .ObRdEn(ObRdEn2), .ObRdAddr(ObRdAddr2), .ObRdData(ObRdData2),
    .m_valid(m_valid2), .m_ready(1'b1), .m_data(m_data2), .m_last(m_last2), .busy(busy2), .done(done2)
  );
  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    logic [31:0] h;
    h = (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    return {h, ~h, h + 32'd1, h ^ 32'h0000FFFF};
  endfunction
  logic [DW-1:0] md [LAT];
  logic [DW-1:0] md2 [LAT2];
  assign ObRdData = md[LAT-1];
  assign ObRdData2 = md2[LAT2-1];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) md[i] <= md[i-1];
    md[0] <= ObRdEn ? word(ObRdAddr) : {4{$urandom}};
    for (int i = LAT2 - 1; i > 0; i--) md2[i] <= md2[i-1];
    md2[0] <= ObRdEn2 ? word(ObRdAddr2) : {4{$urandom}};
  end
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  int cyc = 0, ready_pct = 100;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    m_ready = $urandom_range(99) < ready_pct;
  end
  logic [DW:0] eq[$];
  logic [AW-1:0] aq[$];
  logic [DW:0] prev_beat;
  int issued = 0, popped = 0, beats = 0, acc_c = 0, first_lat = 0, done_lat = 0;
  bit busy_m = 0, done_due = 0, rst_d = 1, prev_stall = 0, first_pend = 0;
  always @(negedge clk) begin : mon
    logic [DW:0] e;
    logic [AW-1:0] a;
    int n;
    bit dn;
    if (rst) begin
      eq.delete();
      aq.delete();
      issued = 0;
      popped = 0;
      busy_m = 0;
      done_due = 0;
      prev_stall = 0;
      first_pend = 0;
      rst_d = 1;
    end else begin
      dn = 0;
      chk("cmd_ready", cmd_ready, !busy_m && !rst_d);
      chk("busy", busy, busy_m);
      if (done || done_due) chk("done", done, done_due);
      if (ObRdEn) begin
        issued++;
        if (aq.size() == 0) chk("rd_spurious", 1, 0);
        else chk("rd_addr", ObRdAddr, aq.pop_front());
        chk("credit", (issued - popped) <= DEP, 1);
      end
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_beat", {m_last, m_data}, prev_beat);
      end
      if (first_pend && m_valid) begin
        first_lat = cyc - acc_c;
        first_pend = 0;
      end
      if (m_valid && m_ready) begin
        popped++;
        beats++;
        if (eq.size() == 0) chk("spurious_beat", 1, 0);
        else begin
          e = eq.pop_front();
          chk("beat", {m_last, m_data}, e);
          if (e[DW]) begin
            dn = 1;
            busy_m = 0;
          end
        end
      end else if (m_valid && eq.size() == 0) chk("spurious_valid", m_valid, 0);
      prev_stall = m_valid && !m_ready;
      prev_beat = {m_last, m_data};
      if (done) done_lat = cyc - acc_c;
      if (cmd_valid && cmd_ready) begin
        n = cmd_len > 4096 ? 4096 : int'(cmd_len);
        for (int i = 0; i < n; i++) begin
          a = cmd_addr + AW'(i);
          eq.push_back({i == n - 1, word(a)});
          aq.push_back(a);
        end
        if (n == 0) dn = 1;
        else busy_m = 1;
        acc_c = cyc;
        first_pend = n != 0;
      end
      done_due = dn;
      rst_d = 0;
    end
  end
  task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] l, output bit d);
    cmd_addr = a;
    cmd_len = l;
    cmd_valid = 1;
    d = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        d = done;
        @(posedge clk);
        #1 cmd_valid = 0;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    cmd_valid = 0;
  endtask
  task automatic wait_done(input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("done_timeout", 0, 1);
  endtask
  task automatic run_full(input logic [AW-1:0] a, input logic [LW-1:0] l, input int n);
    bit d;
    send(a, l, d);
    wait_done(n + 50);
    chk("first_lat", first_lat, LAT + 2);
    chk("done_lat", done_lat, LAT + 2 + n);
  endtask
  task automatic chk_reset_vals();
    chk("rst_ctl", {cmd_ready, ObRdEn, m_valid, m_last, busy, done}, 0);
    chk("rst_addr", ObRdAddr, 0);
    chk("rst_data", m_data, 0);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    bit d;
    int b0, k;
    logic [AW-1:0] a2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk);
    #1 rst = 0;
    run_full(12'h010, 4, 4);
    run_full(12'hFFE, 4, 4);
    ready_pct = 30;
    send(12'($urandom), 16, d);
    wait_done(1000);
    repeat (5) begin
      ready_pct = $urandom_range(20, 100);
      send(12'($urandom), 13'($urandom_range(1, 24)), d);
      wait_done(2000);
    end
    ready_pct = 100;
    send(12'h123, 0, d);
    send(12'h200, 3, d);
    chk("b2b_after_zero", d, 1);
    send(12'h300, 2, d);
    chk("b2b_done_cycle", d, 1);
    wait_done(100);
    send(12'h080, 10, d);
    b0 = beats;
    for (k = 0; k < 100 && beats - b0 < 3; k++) @(negedge clk);
    chk("mid_reset_progress", beats - b0 >= 3, 1);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk_reset_vals();
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    run_full(12'h040, 2, 2);
    run_full(12'h7F0, 13'h1FFF, 4096);
    a2 = 12'($urandom);
    cmd_addr2 = a2;
    cmd_len2 = 32;
    cmd_valid2 = 1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cmd_ready2) break;
    end
    chk("d2_accept", cmd_ready2, 1);
    @(posedge clk);
    #1 cmd_valid2 = 0;
    k = 1;
    @(negedge clk);
    while (!m_valid2 && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk("d2_first_lat", k, LAT2 + 2);
    for (int i = 0; i < 32; i++) begin
      chk("d2_valid", m_valid2, 1);
      chk("d2_beat", {m_last2, m_data2}, {i == 31, word(a2 + AW'(i))});
      @(negedge clk);
    end
    chk("d2_done", done2, 1);
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
